// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer
// Read-side consumer for the async FIFO, living entirely in the clk_r domain.
// It issues FIFO reads, absorbs the FIFO's one-cycle registered read latency
// in a 3-entry skid queue, and presents the bytes as a valid/ready stream.
// The stream carries packet framing (m_last every PKT_LEN beats) and a running
// count of delivered beats.
//
// Stream handshake: a beat transfers on every rising edge where
// m_valid & m_ready are both high. While m_valid=1 and m_ready=0, m_data and
// m_last hold their values. m_valid only falls after a transfer. m_ready has
// no combinational path to m_valid, m_data, m_last or fifo_rd_en.

module fifo_rd_streamer #(
    parameter int DW      = 8,
    parameter int PKT_LEN = 16,
    parameter int CW      = 16
) (
    input  logic          clk_r,
    input  logic          rst,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_rd_en,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic [CW-1:0] beat_count,
    output logic          busy
);

    // Last beat index of a packet, held in the width of the packet counter.
    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);
    localparam logic [15:0] PKT_ONE   = 16'd1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    // Three entries are enough to keep one beat per cycle flowing across the
    // two-edge read latency while still stopping reads cleanly on a stall.
    logic [DW-1:0] r_mem [3];
    logic [1:0]    r_head;
    logic [1:0]    r_tail;
    logic [1:0]    r_occ;
    logic          r_inflight;
    logic [15:0]   r_pkt_beat;
    logic [CW-1:0] r_beat_count;

    logic          w_pop;
    logic          w_cap;
    logic [2:0]    w_committed;
    logic          w_room;

    // Circular pointer advance over entries 0,1,2.
    function automatic logic [1:0] f_next_ptr(input logic [1:0] p);
        f_next_ptr = (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A byte arrives on fifo_data the cycle after its read was issued.
    assign w_cap = r_inflight;

    // A beat leaves when the downstream accepts it.
    assign w_pop = m_valid & m_ready;

    // Entries already held plus the one byte that may still be on its way.
    assign w_committed = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_room      = (w_committed < 3'd3);

    // Read issue uses registered state only; fifo_empty is checked here so the
    // FIFO's own empty gating is never relied upon.
    assign fifo_rd_en = !rst & en & !fifo_empty & w_room;

    // Stream outputs come straight from the queue head.
    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_mem[r_head];
    assign m_last     = m_valid & (r_pkt_beat == LAST_BEAT);
    assign beat_count = r_beat_count;
    assign busy       = (r_occ != 2'd0) | r_inflight;

    // Remember whether a read was issued this cycle so its byte is captured next edge.
    always_ff @(posedge clk_r) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
        end
    end

    // Write the returning FIFO byte into the tail entry.
    always_ff @(posedge clk_r) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_cap) begin
            r_mem[r_tail] <= fifo_data;
        end
    end

    // Tail pointer follows captures.
    always_ff @(posedge clk_r) begin
        if (rst) begin
            r_tail <= 2'd0;
        end else if (w_cap) begin
            r_tail <= f_next_ptr(r_tail);
        end
    end

    // Head pointer follows accepted beats.
    always_ff @(posedge clk_r) begin
        if (rst) begin
            r_head <= 2'd0;
        end else if (w_pop) begin
            r_head <= f_next_ptr(r_head);
        end
    end

    // Occupancy: a capture and a pop in the same cycle cancel out.
    always_ff @(posedge clk_r) begin
        if (rst) begin
            r_occ <= 2'd0;
        end else begin
            case ({w_cap, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Position within the current packet; survives en=0 so framing resumes in place.
    always_ff @(posedge clk_r) begin
        if (rst) begin
            r_pkt_beat <= 16'd0;
        end else if (w_pop) begin
            if (r_pkt_beat == LAST_BEAT) begin
                r_pkt_beat <= 16'd0;
            end else begin
                r_pkt_beat <= r_pkt_beat + PKT_ONE;
            end
        end
    end

    // Free-running count of delivered beats, wrapping at 2^CW.
    always_ff @(posedge clk_r) begin
        if (rst) begin
            r_beat_count <= '0;
        end else if (w_pop) begin
            r_beat_count <= r_beat_count + CNT_ONE;
        end
    end

endmodule
